// File: rtl/mod_updown_counter_pkg.sv
// Shared types and step arithmetic for the up/down counter.
package counter_pkg;

  // Counting mode; the reserved encoding behaves as WRAP.
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  // ONESHOT timer state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest counter the helpers support.
  localparam int unsigned CNT_MAX_W = 32;

  // Terminal test: >= when counting up so a lowered max never traps the count.
  function automatic logic at_terminal(input logic [CNT_MAX_W-1:0] cnt,
                                       input logic [CNT_MAX_W-1:0] max,
                                       input logic                 up);
    logic term;
    if (up) begin
      term = (cnt >= max);
    end else begin
      term = (cnt == 32'd0);
    end
    return term;
  endfunction

  // One enabled step. Values stay inside 0..max(max, cnt), so 32-bit
  // arithmetic never wraps and truncation to WIDTH is exact.
  function automatic logic [CNT_MAX_W-1:0] next_count(input logic [CNT_MAX_W-1:0] cnt,
                                                      input logic [CNT_MAX_W-1:0] max,
                                                      input logic                 up,
                                                      input cnt_mode_e            mode);
    logic [CNT_MAX_W-1:0] res;
    logic                 term;
    term = at_terminal(cnt, max, up);
    res  = cnt;
    case (mode)
      CNT_SAT, CNT_ONESHOT: begin
        if (term) begin
          res = cnt;
        end else begin
          res = up ? (cnt + 32'd1) : (cnt - 32'd1);
        end
      end
      default: begin
        if (term) begin
          res = up ? 32'd0 : max;
        end else begin
          res = up ? (cnt + 32'd1) : (cnt - 32'd1);
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Up/down counter with runtime modulus, load, and WRAP / SAT / ONESHOT modes.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up_not_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt_o,
  output logic             rc,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  cnt_mode_e        mode_s;
  logic             term_s;
  logic [WIDTH-1:0] step_s;

  // Next-state decode in priority order clr > abort > load/start > en; rc is combinational.
  always_comb begin
    mode_s  = cnt_mode_e'(mode);
    term_s  = at_terminal(32'(cnt_q), 32'(max_val), up_not_down);
    step_s  = WIDTH'(next_count(32'(cnt_q), 32'(max_val), up_not_down, mode_s));
    rc      = en & term_s;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (clr) begin
      cnt_d   = {WIDTH{1'b0}};
      state_d = ST_IDLE;
    end else if ((state_q == ST_RUN) && (mode_s != CNT_ONESHOT)) begin
      // Leaving ONESHOT mid-run aborts silently; the count holds.
      state_d = ST_IDLE;
    end else if (mode_s == CNT_ONESHOT) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_d   = load_val;
            state_d = ST_RUN;
          end else if (load) begin
            cnt_d = load_val;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RUN: begin
          if (en && term_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (en) begin
            cnt_d = step_s;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      if (load) begin
        cnt_d = load_val;
      end else if (en) begin
        cnt_d = step_s;
      end else begin
        cnt_d = cnt_q;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= {WIDTH{1'b0}};
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o = cnt_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=8): directed scenarios then random traffic.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst, clr, en, up_not_down, load, start;
  logic [1:0] mode;
  logic [7:0] load_val, max_val;
  logic [7:0] cnt_o;
  logic       rc, busy, done;

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       rc;
  } exp_t;

  exp_t exp_q[$];
  int   applied;
  int   miscompares;

  // Reference state, kept as plain integers.
  int m_cnt;
  bit m_run;
  bit m_done;

  mod_updown_counter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up_not_down(up_not_down),
    .mode(mode), .load(load), .start(start), .load_val(load_val),
    .max_val(max_val), .cnt_o(cnt_o), .rc(rc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply one clock edge with the given inputs.
  task automatic model_step(input bit r, input bit c, input bit e, input bit u,
                            input int md, input bit ld, input bit st,
                            input int lv, input int mv);
    bit term;
    term = u ? (m_cnt >= mv) : (m_cnt == 0);
    if (r || c) begin
      m_cnt = 0; m_run = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_run && md != 2) begin
        m_run = 0;
      end else if (md == 2) begin
        if (!m_run) begin
          if (st) begin m_cnt = lv; m_run = 1; end
          else if (ld) m_cnt = lv;
        end else if (e) begin
          if (term) begin m_done = 1; m_run = 0; end
          else m_cnt = u ? m_cnt + 1 : m_cnt - 1;
        end
      end else begin
        if (ld) m_cnt = lv;
        else if (e) begin
          if (md == 1) begin
            if (!term) m_cnt = u ? m_cnt + 1 : m_cnt - 1;
          end else begin
            if (term) m_cnt = u ? 0 : mv;
            else m_cnt = u ? m_cnt + 1 : m_cnt - 1;
          end
        end
      end
    end
    m_cnt = m_cnt & 255;
  endtask

  // Drive one cycle of inputs, queue the expected outputs for this cycle, advance the model.
  task automatic drive(input bit r, input bit c, input bit e, input bit u,
                       input int md, input bit ld, input bit st,
                       input int lv, input int mv);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; en = e; up_not_down = u; mode = md[1:0];
    load = ld; start = st; load_val = lv[7:0]; max_val = mv[7:0];
    x.cnt  = m_cnt[7:0];
    x.busy = m_run;
    x.done = m_done;
    x.rc   = e && (u ? (m_cnt >= mv) : (m_cnt == 0));
    exp_q.push_back(x);
    applied++;
    model_step(r, c, e, u, md, ld, st, lv, mv);
  endtask

  // Monitor: once the inputs have settled each cycle, compare DUT outputs with the queue head.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (cnt_o !== x.cnt) begin
          miscompares++;
          $display("FAIL cnt @%0t: got %0d want %0d", $time, cnt_o, x.cnt);
        end
        if (busy !== x.busy) begin
          miscompares++;
          $display("FAIL busy @%0t: got %0b want %0b", $time, busy, x.busy);
        end
        if (done !== x.done) begin
          miscompares++;
          $display("FAIL done @%0t: got %0b want %0b", $time, done, x.done);
        end
        if (rc !== x.rc) begin
          miscompares++;
          $display("FAIL rc @%0t: got %0b want %0b", $time, rc, x.rc);
        end
      end
    end
  end

  // Stimulus: reset, directed scenarios, random traffic, drain, summary.
  initial begin
    applied = 0; miscompares = 0;
    rst = 1'b1; clr = 1'b0; en = 1'b0; up_not_down = 1'b1; mode = 2'b00;
    load = 1'b0; start = 1'b0; load_val = 8'd0; max_val = 8'd0;
    repeat (2) @(posedge clk);
    m_cnt = 0; m_run = 0; m_done = 0;

    // Reset state, then WRAP up to 9 and around.
    drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 0, 0, 0, 0, 9);
    // WRAP down from 2 through 0 to 9.
    drive(0, 0, 0, 0, 0, 1, 0, 2, 9);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 0, 0, 9);
    // SAT up to 5 and hold, then down from 1 to 0 and hold.
    drive(0, 1, 0, 1, 1, 0, 0, 0, 5);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 1, 0, 0, 0, 5);
    drive(0, 0, 0, 0, 1, 1, 0, 1, 5);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 1, 0, 0, 0, 5);
    // ONESHOT down from 3, done pulse, then IDLE ignores en.
    drive(0, 1, 0, 0, 2, 0, 0, 0, 9);
    drive(0, 0, 0, 0, 2, 0, 1, 3, 9);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 2, 0, 0, 0, 9);
    // Reset in the middle of a run at count 2.
    drive(0, 0, 0, 0, 2, 0, 1, 5, 9);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 2, 0, 0, 0, 9);
    drive(1, 0, 1, 0, 2, 0, 0, 0, 9);
    drive(0, 0, 0, 0, 2, 0, 0, 0, 9);
    // clr beats load in the same cycle.
    drive(0, 0, 0, 1, 0, 1, 0, 7, 9);
    drive(0, 1, 0, 1, 0, 1, 0, 7, 9);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
    // Count above a lowered max wraps to 0.
    drive(0, 0, 0, 1, 0, 1, 0, 200, 250);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 9);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
    // Start at terminal, mode change aborts a run.
    drive(0, 0, 0, 0, 2, 0, 1, 0, 9);
    drive(0, 0, 1, 0, 2, 0, 0, 0, 9);
    drive(0, 0, 0, 0, 2, 0, 1, 6, 9);
    drive(0, 0, 1, 0, 2, 0, 0, 0, 9);
    drive(0, 0, 1, 0, 1, 1, 0, 3, 9);
    drive(0, 0, 1, 0, 1, 0, 0, 0, 9);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int mv, lv;
      mv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 2 - $urandom_range(0, 1) * 2 + $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), lv, mv);
    end

    // Drain the scoreboard with a bounded wait.
    drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
